// File: rtl/pattern_loader_if.sv
// pattern_loader_if: handshake and write-port bundle around pattern_loader.
//   load_in/pattern_in/seed_in : load request with the pattern and LFSR seed
//   start_in/start_out         : logic window start, synchronizer -> life_logic
//   done_in/done_out           : logic window done, life_logic -> synchronizer
//   logic_*_w_in/logic_wr_en_in: life_logic write port
//   addr_w_out/data_w_out/wr_en_out : double_buffer logic write port
//   busy_out                   : loader armed or filling
// slave = the loader, master = whatever drives it (a bench or the top level).
interface pattern_loader_if #(
  parameter int ADDR_WIDTH = 13,
  parameter int DATA_WIDTH = 32
);
  logic                  load_in;
  logic [1:0]            pattern_in;
  logic [15:0]           seed_in;
  logic                  start_in;
  logic                  start_out;
  logic                  done_in;
  logic                  done_out;
  logic [ADDR_WIDTH-1:0] logic_addr_w_in;
  logic [DATA_WIDTH-1:0] logic_data_w_in;
  logic                  logic_wr_en_in;
  logic [ADDR_WIDTH-1:0] addr_w_out;
  logic [DATA_WIDTH-1:0] data_w_out;
  logic                  wr_en_out;
  logic                  busy_out;

  modport slave (
    input  load_in, pattern_in, seed_in, start_in, done_in,
           logic_addr_w_in, logic_data_w_in, logic_wr_en_in,
    output start_out, done_out, addr_w_out, data_w_out, wr_en_out, busy_out
  );

  modport master (
    output load_in, pattern_in, seed_in, start_in, done_in,
           logic_addr_w_in, logic_data_w_in, logic_wr_en_in,
    input  start_out, done_out, addr_w_out, data_w_out, wr_en_out, busy_out
  );
endinterface

// File: rtl/pattern_loader.sv
// pattern_loader: sits between the frame synchronizer, life_logic and the
// double_buffer logic write port. Idle, it is transparent. After a load
// request it steals the next logic window: life_logic is not started, the
// whole back buffer is written with a seed pattern (clear, Galois-LFSR random,
// R-pentomino, checkerboard) one word per cycle, then done is reported so the
// synchronizer swaps the freshly seeded buffer to the display.
// Ports:
//   clk_in : system clock
//   rst_in : synchronous active-high reset
//   bus    : pattern_loader_if.slave (request, start/done, write ports, busy)
module pattern_loader #(
  parameter int WORDS      = 8192,
  parameter int ROW_WORDS  = 16,
  parameter int ADDR_WIDTH = 13,
  parameter int DATA_WIDTH = 32
) (
  input  logic              clk_in,
  input  logic              rst_in,
  pattern_loader_if.slave   bus
);

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_FILL, S_FINISH} state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(WORDS - 1);
  localparam int ROW_SHIFT = $clog2(ROW_WORDS);

  // R-pentomino centred on the board: three rows starting one row above the
  // middle, leftmost cell at the first bit of the middle word of the row.
  localparam int R_ROW = WORDS / ROW_WORDS / 2 - 1;
  localparam int R_COL = ROW_WORDS / 2;
  localparam logic [ADDR_WIDTH-1:0] R_A0 = ADDR_WIDTH'(R_ROW * ROW_WORDS + R_COL);
  localparam logic [ADDR_WIDTH-1:0] R_A1 = ADDR_WIDTH'((R_ROW + 1) * ROW_WORDS + R_COL);
  localparam logic [ADDR_WIDTH-1:0] R_A2 = ADDR_WIDTH'((R_ROW + 2) * ROW_WORDS + R_COL);
  localparam logic [DATA_WIDTH-1:0] R_TOP = {4'b0110, {(DATA_WIDTH-4){1'b0}}};
  localparam logic [DATA_WIDTH-1:0] R_MID = {4'b1100, {(DATA_WIDTH-4){1'b0}}};
  localparam logic [DATA_WIDTH-1:0] R_BOT = {4'b0100, {(DATA_WIDTH-4){1'b0}}};

  localparam logic [DATA_WIDTH-1:0] LFSR_TAPS = DATA_WIDTH'(32'h8020_0003);

  state_t                state_q;
  logic [1:0]            pat_q;
  logic [15:0]           seed_q;
  logic [DATA_WIDTH-1:0] lfsr_q, lfsr_d;
  logic [ADDR_WIDTH-1:0] cnt_q;
  logic [DATA_WIDTH-1:0] fill_word;
  logic                  pass;

  // Galois step: shift right, fold taps in when the bit shifted out was 1.
  assign lfsr_d = {1'b0, lfsr_q[DATA_WIDTH-1:1]} ^ (lfsr_q[0] ? LFSR_TAPS : '0);

  always_comb begin
    fill_word = '0;
    case (pat_q)
      2'd1: fill_word = lfsr_q;
      2'd2: begin
        if (cnt_q == R_A0) fill_word = R_TOP;
        if (cnt_q == R_A1) fill_word = R_MID;
        if (cnt_q == R_A2) fill_word = R_BOT;
      end
      2'd3: fill_word = cnt_q[ROW_SHIFT] ? {(DATA_WIDTH/2){2'b01}}
                                         : {(DATA_WIDTH/2){2'b10}};
      default: fill_word = '0;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= S_IDLE;
      pat_q   <= '0;
      seed_q  <= '0;
      lfsr_q  <= '0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          // A load coinciding with start only arms; this window passes through.
          if (bus.load_in) begin
            pat_q   <= bus.pattern_in;
            seed_q  <= bus.seed_in;
            state_q <= S_ARMED;
          end
        end
        S_ARMED: begin
          if (bus.start_in) begin
            state_q <= S_FILL;
            cnt_q   <= '0;
            // {s,~s} is never all-zero, so the LFSR cannot lock up.
            lfsr_q  <= DATA_WIDTH'({seed_q, ~seed_q});
          end else if (bus.load_in) begin
            pat_q  <= bus.pattern_in;
            seed_q <= bus.seed_in;
          end
        end
        S_FILL: begin
          lfsr_q <= lfsr_d;
          if (cnt_q == LAST_ADDR) state_q <= S_FINISH;
          else                    cnt_q   <= cnt_q + 1'b1;
        end
        S_FINISH: state_q <= S_IDLE;
        default:  state_q <= S_IDLE;
      endcase
    end
  end

  assign pass = (state_q == S_IDLE) || (state_q == S_ARMED);

  // Control outputs are masked during reset so nothing leaks out of an
  // aborted fill; addr/data are don't-care whenever wr_en_out is low.
  always_comb begin
    bus.start_out  = !rst_in && (state_q == S_IDLE) && bus.start_in;
    bus.done_out   = !rst_in && ((pass && bus.done_in) || (state_q == S_FINISH));
    bus.wr_en_out  = !rst_in && (pass ? bus.logic_wr_en_in : (state_q == S_FILL));
    bus.busy_out   = !rst_in && (state_q != S_IDLE);
    bus.addr_w_out = bus.logic_addr_w_in;
    bus.data_w_out = bus.logic_data_w_in;
    if (state_q == S_FILL) begin
      bus.addr_w_out = cnt_q;
      bus.data_w_out = fill_word;
    end
  end

endmodule

// File: tb/tb_pattern_loader.sv
module tb_pattern_loader;
  localparam int WORDS = 8192;
  localparam int AW    = 13;
  localparam int DW    = 32;

  logic clk_in = 1'b0;
  logic rst_in = 1'b1;
  always #5 clk_in = ~clk_in;

  pattern_loader_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  pattern_loader #(.WORDS(WORDS), .ROW_WORDS(16), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .bus    (bus)
  );

  int checks = 0;
  int passed = 0;
  logic [DW-1:0] cap [WORDS];

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic idle_inputs();
    bus.load_in = 0; bus.pattern_in = 0; bus.seed_in = 0;
    bus.start_in = 0; bus.done_in = 0;
    bus.logic_addr_w_in = 0; bus.logic_data_w_in = 0; bus.logic_wr_en_in = 0;
  endtask

  task automatic arm(input logic [1:0] pat, input logic [15:0] seed);
    bus.load_in = 1; bus.pattern_in = pat; bus.seed_in = seed;
    tick();
    bus.load_in = 0;
  endtask

  // Drives one fill window and records what happened; tests judge the record.
  // inj_at >= 0 fires a load (pattern 3) plus stray start/done/logic writes
  // at that word, all of which must be ignored.
  task automatic run_fill(input int inj_at, output int start_seen, output int seq_err,
                          output int fin_done, output int fin_wr,
                          output int post_done, output int post_busy);
    bus.start_in = 1;
    #1 start_seen = int'(bus.start_out);
    tick();
    bus.start_in = 0;
    seq_err = 0;
    for (int i = 0; i < WORDS; i++) begin
      if (i == inj_at) begin
        bus.load_in = 1; bus.pattern_in = 3; bus.seed_in = 16'h1234;
        bus.start_in = 1; bus.done_in = 1;
        bus.logic_wr_en_in = 1; bus.logic_addr_w_in = 0; bus.logic_data_w_in = '1;
      end else idle_inputs();
      #1;
      if (!bus.wr_en_out || bus.addr_w_out != AW'(i) || bus.done_out ||
          bus.start_out || !bus.busy_out) seq_err++;
      cap[i] = bus.data_w_out;
      tick();
    end
    idle_inputs();
    #1;
    fin_done = int'(bus.done_out);
    fin_wr   = int'(bus.wr_en_out);
    tick();
    post_done = int'(bus.done_out);
    post_busy = int'(bus.busy_out);
  endtask

  task automatic check_window(input string nm, input int start_seen, input int seq_err,
                              input int fin_done, input int fin_wr,
                              input int post_done, input int post_busy);
    checks++; if (start_seen !== 0) $display("FAIL %s_start_out: got %0d want 0", nm, start_seen); else passed++;
    checks++; if (seq_err !== 0) $display("FAIL %s_write_seq: %0d bad cycles want 0", nm, seq_err); else passed++;
    checks++; if (fin_done !== 1) $display("FAIL %s_done_pulse: got %0d want 1", nm, fin_done); else passed++;
    checks++; if (fin_wr !== 0) $display("FAIL %s_finish_wr: got %0d want 0", nm, fin_wr); else passed++;
    checks++; if (post_done !== 0) $display("FAIL %s_done_single: got %0d want 0", nm, post_done); else passed++;
    checks++; if (post_busy !== 0) $display("FAIL %s_busy_after: got %0d want 0", nm, post_busy); else passed++;
  endtask

  task automatic test_reset();
    rst_in = 1;
    bus.start_in = 1; bus.done_in = 1; bus.logic_wr_en_in = 1; bus.logic_addr_w_in = 13'd7;
    tick(); tick();
    checks++; if (bus.start_out !== 1'b0) $display("FAIL rst_start: got %b want 0", bus.start_out); else passed++;
    checks++; if (bus.done_out !== 1'b0) $display("FAIL rst_done: got %b want 0", bus.done_out); else passed++;
    checks++; if (bus.wr_en_out !== 1'b0) $display("FAIL rst_wr_en: got %b want 0", bus.wr_en_out); else passed++;
    checks++; if (bus.busy_out !== 1'b0) $display("FAIL rst_busy: got %b want 0", bus.busy_out); else passed++;
    checks++; if (bus.addr_w_out !== 13'd7) $display("FAIL rst_addr_pass: got %0d want 7", bus.addr_w_out); else passed++;
    idle_inputs();
    rst_in = 0;
    tick();
  endtask

  task automatic test_passthrough();
    bus.logic_wr_en_in = 1; bus.logic_addr_w_in = 13'd5; bus.logic_data_w_in = 32'h1234;
    #1;
    checks++; if (bus.wr_en_out !== 1'b1) $display("FAIL pt_wr_en: got %b want 1", bus.wr_en_out); else passed++;
    checks++; if (bus.addr_w_out !== 13'd5) $display("FAIL pt_addr: got %0d want 5", bus.addr_w_out); else passed++;
    checks++; if (bus.data_w_out !== 32'h1234) $display("FAIL pt_data: got %h want 00001234", bus.data_w_out); else passed++;
    bus.start_in = 1; #1;
    checks++; if (bus.start_out !== 1'b1) $display("FAIL pt_start: got %b want 1", bus.start_out); else passed++;
    bus.start_in = 0; bus.done_in = 1; #1;
    checks++; if (bus.done_out !== 1'b1) $display("FAIL pt_done: got %b want 1", bus.done_out); else passed++;
    checks++; if (bus.busy_out !== 1'b0) $display("FAIL pt_busy: got %b want 0", bus.busy_out); else passed++;
    idle_inputs();
    tick();
  endtask

  task automatic test_clear();
    int s, e, fd, fw, pd, pb, bad;
    arm(2'd0, 16'hBEEF);
    bus.logic_wr_en_in = 1; bus.logic_addr_w_in = 13'd9; #1;
    checks++; if (bus.busy_out !== 1'b1) $display("FAIL clr_busy_armed: got %b want 1", bus.busy_out); else passed++;
    checks++; if (bus.wr_en_out !== 1'b1) $display("FAIL clr_armed_pass: got %b want 1", bus.wr_en_out); else passed++;
    idle_inputs();
    run_fill(-1, s, e, fd, fw, pd, pb);
    check_window("clr", s, e, fd, fw, pd, pb);
    bad = 0;
    for (int i = 0; i < WORDS; i++) if (cap[i] !== 32'h0) bad++;
    checks++; if (bad !== 0) $display("FAIL clr_data: %0d nonzero words want 0", bad); else passed++;
  endtask

  task automatic test_random();
    int s, e, fd, fw, pd, pb, bad, zeros;
    logic [31:0] m;
    arm(2'd1, 16'h0000);
    run_fill(-1, s, e, fd, fw, pd, pb);
    check_window("rnd", s, e, fd, fw, pd, pb);
    // {0000,FFFF}: bit0=1 -> 0000_7FFF ^ 8020_0003 = 8020_7FFC
    checks++; if (cap[0] !== 32'h0000FFFF) $display("FAIL rnd_word0: got %h want 0000ffff", cap[0]); else passed++;
    checks++; if (cap[1] !== 32'h80207FFC) $display("FAIL rnd_word1: got %h want 80207ffc", cap[1]); else passed++;
    bad = 0; zeros = 0; m = 32'h0000FFFF;
    for (int i = 0; i < WORDS; i++) begin
      if (cap[i] !== m) bad++;
      if (cap[i] === 32'h0) zeros++;
      m = {1'b0, m[31:1]} ^ (m[0] ? 32'h80200003 : 32'h0);
    end
    checks++; if (zeros !== 0) $display("FAIL rnd_nonzero: %0d zero words want 0", zeros); else passed++;
    checks++; if (bad !== 0) $display("FAIL rnd_sequence: %0d wrong words want 0", bad); else passed++;
  endtask

  task automatic test_rpentomino();
    int s, e, fd, fw, pd, pb, nz;
    arm(2'd2, 16'h5A5A);
    run_fill(-1, s, e, fd, fw, pd, pb);
    check_window("rp", s, e, fd, fw, pd, pb);
    nz = 0;
    for (int i = 0; i < WORDS; i++) if (cap[i] !== 32'h0) nz++;
    checks++; if (nz !== 3) $display("FAIL rp_count: %0d nonzero words want 3", nz); else passed++;
    checks++; if (cap[4088] !== 32'h60000000) $display("FAIL rp_4088: got %h want 60000000", cap[4088]); else passed++;
    checks++; if (cap[4104] !== 32'hC0000000) $display("FAIL rp_4104: got %h want c0000000", cap[4104]); else passed++;
    checks++; if (cap[4120] !== 32'h40000000) $display("FAIL rp_4120: got %h want 40000000", cap[4120]); else passed++;
  endtask

  task automatic test_checker_coincident();
    int s, e, fd, fw, pd, pb, bad;
    // load and start together in IDLE: start passes, loader only arms
    bus.load_in = 1; bus.pattern_in = 2'd3; bus.start_in = 1; #1;
    checks++; if (bus.start_out !== 1'b1) $display("FAIL co_start_pass: got %b want 1", bus.start_out); else passed++;
    tick();
    idle_inputs();
    checks++; if (bus.busy_out !== 1'b1) $display("FAIL co_armed: got %b want 1", bus.busy_out); else passed++;
    run_fill(-1, s, e, fd, fw, pd, pb);
    check_window("chk", s, e, fd, fw, pd, pb);
    checks++; if (cap[0] !== 32'hAAAAAAAA) $display("FAIL chk_addr0: got %h want aaaaaaaa", cap[0]); else passed++;
    checks++; if (cap[16] !== 32'h55555555) $display("FAIL chk_addr16: got %h want 55555555", cap[16]); else passed++;
    bad = 0;
    for (int i = 0; i < WORDS; i++)
      if (cap[i] !== (((i / 16) % 2 == 0) ? 32'hAAAAAAAA : 32'h55555555)) bad++;
    checks++; if (bad !== 0) $display("FAIL chk_all: %0d wrong words want 0", bad); else passed++;
  endtask

  task automatic test_latest_wins_and_fill_load();
    int s, e, fd, fw, pd, pb, bad;
    arm(2'd3, 16'h0001);
    arm(2'd0, 16'h0002);
    run_fill(10, s, e, fd, fw, pd, pb);
    check_window("lw", s, e, fd, fw, pd, pb);
    bad = 0;
    for (int i = 0; i < WORDS; i++) if (cap[i] !== 32'h0) bad++;
    checks++; if (bad !== 0) $display("FAIL lw_clear_used: %0d nonzero words want 0", bad); else passed++;
  endtask

  task automatic test_reset_mid_fill();
    int dn;
    arm(2'd3, 16'h0000);
    bus.start_in = 1; tick(); bus.start_in = 0;
    repeat (100) tick();
    checks++; if (bus.wr_en_out !== 1'b1 || bus.addr_w_out !== 13'd100)
      $display("FAIL mid_word100: wr_en %b addr %0d want 1/100", bus.wr_en_out, bus.addr_w_out); else passed++;
    rst_in = 1;
    tick();
    rst_in = 0; #1;
    checks++; if (bus.wr_en_out !== 1'b0) $display("FAIL mid_wr_drop: got %b want 0", bus.wr_en_out); else passed++;
    checks++; if (bus.busy_out !== 1'b0) $display("FAIL mid_busy: got %b want 0", bus.busy_out); else passed++;
    dn = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus.done_out !== 1'b0 || bus.wr_en_out !== 1'b0) dn++;
      tick();
    end
    checks++; if (dn !== 0) $display("FAIL mid_no_done: %0d cycles with done/wr want 0", dn); else passed++;
    bus.start_in = 1; #1;
    checks++; if (bus.start_out !== 1'b1) $display("FAIL mid_start_pass: got %b want 1", bus.start_out); else passed++;
    tick();
    bus.start_in = 0; #1;
    checks++; if (bus.busy_out !== 1'b0) $display("FAIL mid_idle_after: got %b want 0", bus.busy_out); else passed++;
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_passthrough();
    test_clear();
    test_random();
    test_rpentomino();
    test_checker_coincident();
    test_latest_wins_and_fill_load();
    test_reset_mid_fill();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
